socetlib_fifo_uart_tx: RTL and testbench

- Drains a socetlib_fifo from its read side and serialises each byte onto an 8N1/8E1/8N2-style UART line.
- Sits between the TX byte FIFO and the chip's tx pad.
- Owns the FIFO's REN strobe and consumes its empty/rdata outputs directly.
- Pops exactly one byte per frame and never issues a read against an empty FIFO.

---
 rtl/socetlib_fifo_uart_tx.sv | 147 ++++++++++++++
 tb/tb_socetlib_fifo_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/socetlib_fifo_uart_tx.sv
// Pulls bytes from a socetlib_fifo read port and shifts them out as UART frames
// (start, 8 data bits LSB first, optional even parity, 1 or 2 stop bits).
module socetlib_fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_BITS     = $clog2(CLKS_PER_BIT)
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_ren,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(CLKS_PER_BIT - 1);
    localparam logic LAST_STOP_IDX = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    state_t              state_reg, state_next;
    logic [CNT_BITS-1:0] cnt_reg, cnt_next;
    logic [2:0]          bit_idx_reg, bit_idx_next;
    logic                stop_idx_reg, stop_idx_next;
    logic [7:0]          shift_reg, shift_next;
    logic                parity_reg, parity_next;
    logic                tx_reg, tx_next;
    logic                busy_reg, busy_next;

    logic bit_end;
    logic last_stop;
    logic pop;

    assign bit_end   = (state_reg != IDLE) && (cnt_reg == CNT_MAX);
    assign last_stop = (stop_idx_reg == LAST_STOP_IDX);
    // Gated by nRST so the FIFO never sees a read while this block is held in reset.
    assign pop = nRST & enable & ~fifo_empty &
                 ((state_reg == IDLE) || ((state_reg == STOP) && last_stop && bit_end));

    assign fifo_ren   = pop;
    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = (state_reg == STOP) && last_stop && bit_end;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        stop_idx_next = stop_idx_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;

        if (state_reg == IDLE) begin
            cnt_next = '0;
        end else if (bit_end) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_BITS'(1);
        end

        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next  = START;
                    shift_next  = fifo_rdata;
                    parity_next = ^fifo_rdata;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_idx_next = 1'b0;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    stop_idx_next = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!last_stop) begin
                        stop_idx_next = 1'b1;
                    end else if (pop) begin
                        state_next  = START;
                        shift_next  = fifo_rdata;
                        parity_next = ^fifo_rdata;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx and busy are computed from the next state so they line up with state_reg.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            stop_idx_reg <= stop_idx_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
        end
    end

endmodule

// File: tb/tb_socetlib_fifo_uart_tx.sv
// Directed bench: an 8N1 instance (a) and an 8E2 instance (b), each fed by a small FIFO model.
module tb_socetlib_fifo_uart_tx;

    logic CLK;
    logic nRST;

    logic       enable_a, fifo_empty_a, fifo_ren_a, tx_a, busy_a, frame_done_a;
    logic [7:0] fifo_rdata_a;
    logic       enable_b, fifo_empty_b, fifo_ren_b, tx_b, busy_b, frame_done_b;
    logic [7:0] fifo_rdata_b;

    int checks = 0;
    int errors = 0;

    // FIFO models
    logic [7:0] mem_a [0:15];
    logic [7:0] mem_b [0:15];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    logic underrun_a = 1'b0, underrun_b = 1'b0;

    assign fifo_empty_a = (wr_a == rd_a);
    assign fifo_rdata_a = mem_a[rd_a[3:0]];
    assign fifo_empty_b = (wr_b == rd_b);
    assign fifo_rdata_b = mem_b[rd_b[3:0]];

    always @(posedge CLK) begin
        if (fifo_ren_a) begin
            if (fifo_empty_a) underrun_a <= 1'b1;
            else rd_a <= rd_a + 1;
        end
        if (fifo_ren_b) begin
            if (fifo_empty_b) underrun_b <= 1'b1;
            else rd_b <= rd_b + 1;
        end
    end

    socetlib_fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .nRST(nRST), .enable(enable_a), .fifo_empty(fifo_empty_a),
        .fifo_rdata(fifo_rdata_a), .fifo_ren(fifo_ren_a), .tx(tx_a), .busy(busy_a),
        .frame_done(frame_done_a)
    );

    socetlib_fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .nRST(nRST), .enable(enable_b), .fifo_empty(fifo_empty_b),
        .fifo_rdata(fifo_rdata_b), .fifo_ren(fifo_ren_b), .tx(tx_b), .busy(busy_b),
        .frame_done(frame_done_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic push_a(input logic [7:0] b);
        mem_a[wr_a[3:0]] = b;
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [7:0] b);
        mem_b[wr_b[3:0]] = b;
        wr_b = wr_b + 1;
    endtask

    // Expected 8N1 line level at cycle k of a frame with CLKS_PER_BIT=4.
    function automatic logic exp_tx_a(input int k, input logic [7:0] b);
        if (k < 4) return 1'b0;
        if (k < 36) return b[(k - 4) / 4];
        return 1'b1;
    endfunction

    // Called right after the pop cycle; walks the 40 cycles of one frame on instance a.
    task automatic check_frame_a(input logic [7:0] b, input bit next_pop, input int drop_at);
        logic [7:0] decoded;
        bit reported;
        int bad;
        decoded  = 8'h00;
        reported = 0;
        bad      = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (k >= 4 && k < 36 && ((k - 4) % 4) == 2) decoded[(k - 4) / 4] = tx_a;
            checks++;
            if (tx_a !== exp_tx_a(k, b) || busy_a !== 1'b1 ||
                frame_done_a !== (k == 39) || fifo_ren_a !== (next_pop && k == 39)) begin
                errors++;
                bad++;
                if (!reported) begin
                    $display("FAIL frame_a_%02h cycle %0d: tx=%b busy=%b done=%b ren=%b, required tx=%b busy=1 done=%b ren=%b",
                             b, k, tx_a, busy_a, frame_done_a, fifo_ren_a, exp_tx_a(k, b),
                             (k == 39), (next_pop && k == 39));
                    reported = 1;
                end
            end
            if (k == drop_at) enable_a = 1'b0;
        end
        checks++;
        if (decoded !== b) begin
            errors++;
            $display("FAIL decode_a: got 0x%02h, required 0x%02h", decoded, b);
        end
        $display("frame a 0x%02h: 40 cycles, decoded 0x%02h, %0d bad cycles", b, decoded, bad);
    endtask

    task automatic check_idle_a(input int n, input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || fifo_ren_a !== 1'b0 || frame_done_a !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d non-idle cycles (tx=%b busy=%b ren=%b), required 0", name, bad,
                     tx_a, busy_a, fifo_ren_a);
        end
    endtask

    task automatic expect_pop_a(input string name);
        #1;
        checks++;
        if (fifo_ren_a !== 1'b1) begin
            errors++;
            $display("FAIL %s: fifo_ren=%b, required 1", name, fifo_ren_a);
        end
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        enable_a = 1'b0;
        enable_b = 1'b0;
        push_a(8'h55);
        enable_a = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || frame_done_a !== 1'b0 || fifo_ren_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: tx=%b busy=%b done=%b ren=%b, required 1 0 0 0",
                     tx_a, busy_a, frame_done_a, fifo_ren_a);
        end
        checks++;
        if (tx_b !== 1'b1 || busy_b !== 1'b0 || frame_done_b !== 1'b0 || fifo_ren_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: tx=%b busy=%b done=%b ren=%b, required 1 0 0 0",
                     tx_b, busy_b, frame_done_b, fifo_ren_b);
        end
        $display("reset: held 3 cycles with byte queued and enable high");
    endtask

    task automatic test_single_byte;
        nRST = 1'b1;
        expect_pop_a("single_pop");
        check_frame_a(8'h55, 0, -1);
        check_idle_a(4, "single_idle_after");
    endtask

    task automatic test_back_to_back;
        enable_a = 1'b0;
        push_a(8'hA5);
        push_a(8'h3C);
        @(negedge CLK);
        enable_a = 1'b1;
        expect_pop_a("b2b_pop1");
        check_frame_a(8'hA5, 1, -1);
        check_frame_a(8'h3C, 0, -1);
        check_idle_a(4, "b2b_idle_after");
        checks++;
        if (fifo_empty_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty: fifo_empty=%b, required 1", fifo_empty_a);
        end
    endtask

    task automatic test_empty_fifo;
        enable_a = 1'b1;
        check_idle_a(100, "empty_100");
        checks++;
        if (underrun_a !== 1'b0) begin
            errors++;
            $display("FAIL empty_underrun: underrun=%b, required 0", underrun_a);
        end
        $display("empty fifo: 100 cycles with enable high");
    endtask

    task automatic test_enable_drop;
        enable_a = 1'b0;
        push_a(8'h81);
        push_a(8'h42);
        @(negedge CLK);
        enable_a = 1'b1;
        expect_pop_a("drop_pop1");
        check_frame_a(8'h81, 0, 12);
        check_idle_a(20, "drop_idle");
        checks++;
        if (fifo_empty_a !== 1'b0 || fifo_rdata_a !== 8'h42) begin
            errors++;
            $display("FAIL drop_queued: empty=%b rdata=0x%02h, required 0 0x42", fifo_empty_a, fifo_rdata_a);
        end
        enable_a = 1'b1;
        expect_pop_a("drop_pop2");
        check_frame_a(8'h42, 0, -1);
        check_idle_a(2, "drop_idle_after");
    endtask

    task automatic test_reset_mid_frame;
        enable_a = 1'b0;
        push_a(8'h99);
        push_a(8'h66);
        @(negedge CLK);
        enable_a = 1'b1;
        expect_pop_a("rst_pop1");
        repeat (12) @(negedge CLK);
        #2;
        nRST = 1'b0;
        enable_a = 1'b0;
        #1;
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || fifo_ren_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: tx=%b busy=%b ren=%b, required 1 0 0", tx_a, busy_a, fifo_ren_a);
        end
        @(negedge CLK);
        nRST = 1'b1;
        check_idle_a(5, "rst_idle");
        checks++;
        if (fifo_rdata_a !== 8'h66) begin
            errors++;
            $display("FAIL rst_head: rdata=0x%02h, required 0x66", fifo_rdata_a);
        end
        enable_a = 1'b1;
        expect_pop_a("rst_pop2");
        check_frame_a(8'h66, 0, -1);
        check_idle_a(2, "rst_idle_after");
    endtask

    task automatic test_parity;
        logic exp;
        int busy_cycles;
        bit reported;
        push_b(8'h07);
        @(negedge CLK);
        enable_b = 1'b1;
        #1;
        checks++;
        if (fifo_ren_b !== 1'b1) begin
            errors++;
            $display("FAIL par_pop: fifo_ren=%b, required 1", fifo_ren_b);
        end
        busy_cycles = 0;
        reported = 0;
        for (int k = 0; k < 52; k++) begin
            @(negedge CLK);
            if (busy_b === 1'b1) busy_cycles++;
            if (k < 4) exp = 1'b0;
            else if (k < 36) exp = (8'h07 >> ((k - 4) / 4)) & 8'h01 ? 1'b1 : 1'b0;
            else if (k < 40) exp = 1'b1;    // even parity of 0x07 (three ones)
            else exp = 1'b1;
            checks++;
            if (tx_b !== exp || frame_done_b !== (k == 47) || busy_b !== (k < 48) || fifo_ren_b !== 1'b0) begin
                errors++;
                if (!reported) begin
                    $display("FAIL par_frame cycle %0d: tx=%b done=%b busy=%b ren=%b, required tx=%b done=%b busy=%b ren=0",
                             k, tx_b, frame_done_b, busy_b, fifo_ren_b, exp, (k == 47), (k < 48));
                    reported = 1;
                end
            end
        end
        checks++;
        if (busy_cycles != 48) begin
            errors++;
            $display("FAIL par_length: %0d busy cycles, required 48", busy_cycles);
        end
        $display("frame b 0x07 (8E2): %0d busy cycles", busy_cycles);
        enable_b = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_empty_fifo;
        test_enable_drop;
        test_reset_mid_frame;
        test_parity;
        checks++;
        if (underrun_a !== 1'b0 || underrun_b !== 1'b0) begin
            errors++;
            $display("FAIL final_underrun: a=%b b=%b, required 0 0", underrun_a, underrun_b);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
